// File: rtl/load_store_unit.sv
// RV32 load/store unit in front of a word-addressed, byte-enable-less data memory.
// Optional LSU_ALIGN_CHECK_EN: misaligned accesses return an error instead of being force-aligned.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam int AL_W = MEM_AW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic            write_r;
    logic [2:0]      funct3_r;
    logic [AL_W-1:0] addr_r;
    logic [31:0]     wdata_r;
    logic [31:0]     resp_data_r;
    logic            resp_err_r;

    logic            illegal_s;
    logic            misaligned_s;
    logic            err_s;
    logic [AL_W-1:0] aligned_addr_s;
    logic            addr_unused_s;

    assign addr_unused_s = ^req_addr[ADDR_W-1:AL_W];

    // Select the lane and sign/zero-extend a loaded byte or halfword.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the target lane of the read word; other lanes stay bit-exact.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        if (f3[1:0] == 2'b00) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            r[31:16] = wdata[15:0];
        end else begin
            r[15:0] = wdata[15:0];
        end
        return r;
    endfunction

    // Decode legality and alignment of the incoming request.
    always_comb begin
        illegal_s      = 1'b0;
        misaligned_s   = 1'b0;
        aligned_addr_s = req_addr[AL_W-1:0];
        if (req_write) begin
            illegal_s = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            illegal_s = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b01: begin
                misaligned_s      = req_addr[0];
                aligned_addr_s[0] = 1'b0;
            end
            2'b10: begin
                misaligned_s        = (req_addr[1:0] != 2'b00);
                aligned_addr_s[1:0] = 2'b00;
            end
            default: misaligned_s = 1'b0;
        endcase
`ifdef LSU_ALIGN_CHECK_EN
        err_s = illegal_s | misaligned_s;
`else
        err_s = illegal_s;
`endif
    end

    // Request FSM; response registers only change on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            write_r     <= 1'b0;
            funct3_r    <= 3'b000;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            resp_data_r <= 32'h0000_0000;
            resp_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        write_r  <= req_write;
                        funct3_r <= req_funct3;
                        addr_r   <= aligned_addr_s;
                        wdata_r  <= req_wdata;
                        if (err_s) begin
                            resp_err_r  <= 1'b1;
                            resp_data_r <= 32'h0000_0000;
                            state_r     <= RESP;
                        end else if (req_write && (req_funct3 == 3'b010)) begin
                            state_r <= WRITE;
                        end else begin
                            state_r <= READ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (write_r) begin
                        wdata_r <= store_merge(mem_read_data, wdata_r, funct3_r, addr_r[1:0]);
                        state_r <= WRITE;
                    end else begin
                        resp_data_r <= load_extend(mem_read_data, funct3_r, addr_r[1:0]);
                        resp_err_r  <= 1'b0;
                        state_r     <= RESP;
                    end
                end
                WRITE: begin
                    resp_data_r <= 32'h0000_0000;
                    resp_err_r  <= 1'b0;
                    state_r     <= RESP;
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Memory and handshake outputs decode straight from the state register.
    always_comb begin
        req_ready      = (state_r == IDLE);
        resp_valid     = (state_r == RESP);
        resp_data      = resp_data_r;
        resp_err       = resp_err_r;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = 32'h0000_0000;
        case (state_r)
            READ: begin
                mem_read    = 1'b1;
                mem_address = addr_r[AL_W-1:2];
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_address    = addr_r[AL_W-1:2];
                mem_write_data = wdata_r;
            end
            default: mem_read = 1'b0;
        endcase
    end

endmodule
